// File: rtl/serial_adder_ctrl_if.sv
// Handshake bundle for the bit-serial adder: operation request on the
// in_* side, result on the out_* side, plus a busy indicator.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  // The adder block itself
  modport slave (
    input  in_valid, op_a, op_b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

  // The requester / consumer driving the adder
  modport master (
    output in_valid, op_a, op_b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor controller. One full-adder cell processes one
// bit per clock, LSB first; subtraction adds the inverted B operand with a
// carry-in of 1. Result, carry-out and signed overflow are held in DONE
// until the consumer takes them.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  io
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_sum;
  logic             fa_cout;

  // The single arithmetic cell: current LSBs plus the running carry
  fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state and datapath update for accept, serial step and hand-off
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.op_a;
          b_d     = io.sub ? ~io.op_b : io.op_b;
          carry_d = io.sub ? 1'b1 : io.cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        if (cnt_q == LAST_BIT) begin
          // MSB step: carry into MSB vs carry out of MSB gives signed overflow
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.busy      = (state_q == RUN);
  assign io.out_valid = (state_q == DONE);
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;
endmodule

// 1-bit full adder cell
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule
